// File: rtl/shot_slot_controller.sv
// Shot slot pool: allocates fired shots, moves them once per frame, retires them
// off-screen or on hit, and picks one slot per pixel for the shot bitmap. Optional macro: SHOT_AUTOFIRE_EN.
module shot_slot_controller #(
  parameter int NUM_SLOTS       = 4,
  parameter int SHOT_W          = 16,
  parameter int SHOT_H          = 16,
  parameter int SHOT_SPEED      = 4,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        fireReq,
  input  logic [10:0] fireX,
  input  logic [10:0] fireY,
  input  logic        shotHit,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        fireAccepted,
  output logic [3:0]  activeCount
);

  localparam int          SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [11:0] W12    = 12'(SHOT_W);
  localparam logic [11:0] H12    = 12'(SHOT_H);
  localparam logic [10:0] SPD11  = 11'(SHOT_SPEED);
  localparam logic [7:0]  CD8    = 8'(COOLDOWN_FRAMES);

  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [10:0]          x_q [NUM_SLOTS];
  logic [10:0]          x_d [NUM_SLOTS];
  logic [10:0]          y_q [NUM_SLOTS];
  logic [10:0]          y_d [NUM_SLOTS];
  logic [7:0]           cooldown_q, cooldown_d;
  logic                 arm_q, arm_d;
  logic                 fire_acc_q, fire_acc_d;
  logic                 inside_q, inside_d;
  logic [10:0]          offset_x_q, offset_x_d;
  logic [10:0]          offset_y_q, offset_y_d;
  logic [SLOT_W-1:0]    draw_slot_q, draw_slot_d;
  logic                 draw_valid_q, draw_valid_d;

  logic                 fire_ok;
  logic                 free_found;
  logic [NUM_SLOTS-1:0] pix_hit;
  logic [3:0]           count;

  // Slot state: hit retire first, then move, cooldown and fire on the frame pulse
  always_comb begin
    active_d   = active_q;
    x_d        = x_q;
    y_d        = y_q;
    cooldown_d = cooldown_q;
    arm_d      = arm_q;
    fire_acc_d = 1'b0;
    fire_ok    = 1'b0;
    free_found = 1'b0;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (shotHit && draw_valid_q && (draw_slot_q == SLOT_W'(i))) begin
        active_d[i] = 1'b0;
      end
    end

    if (startOfFrame) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (active_d[i]) begin
          if (y_q[i] < SPD11) begin
            active_d[i] = 1'b0;
          end else begin
            y_d[i] = y_q[i] - SPD11;
          end
        end
      end

      if (cooldown_q != 8'd0) begin
        cooldown_d = cooldown_q - 8'd1;
      end

      fire_ok = fireReq && (cooldown_q == 8'd0) && arm_q;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (fire_ok && !free_found && !active_d[i]) begin
          free_found  = 1'b1;
          active_d[i] = 1'b1;
          x_d[i]      = fireX;
          y_d[i]      = fireY;
        end
      end

      if (free_found) begin
        cooldown_d = CD8;
        fire_acc_d = 1'b1;
      end

`ifdef SHOT_AUTOFIRE_EN
      arm_d = 1'b1;
`else
      if (free_found) begin
        arm_d = 1'b0;
      end else if (!fireReq) begin
        arm_d = 1'b1;
      end
`endif
    end
  end

  // Bounds are compared 12 bits wide so X+SHOT_W near the screen edge cannot wrap
  always_comb begin
    pix_hit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pix_hit[i] = active_q[i]
                && (pixelX >= x_q[i]) && ({1'b0, pixelX} < ({1'b0, x_q[i]} + W12))
                && (pixelY >= y_q[i]) && ({1'b0, pixelY} < ({1'b0, y_q[i]} + H12));
    end
  end

  // Descending scan so the lowest-index hitting slot is the last writer
  always_comb begin
    inside_d     = 1'b0;
    offset_x_d   = '0;
    offset_y_d   = '0;
    draw_slot_d  = '0;
    draw_valid_d = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pix_hit[i]) begin
        inside_d     = 1'b1;
        offset_x_d   = pixelX - x_q[i];
        offset_y_d   = pixelY - y_q[i];
        draw_slot_d  = SLOT_W'(i);
        draw_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    count = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count = count + 4'(active_q[i]);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_q     <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      cooldown_q   <= 8'd0;
      arm_q        <= 1'b1;
      fire_acc_q   <= 1'b0;
      inside_q     <= 1'b0;
      offset_x_q   <= '0;
      offset_y_q   <= '0;
      draw_slot_q  <= '0;
      draw_valid_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cooldown_q   <= cooldown_d;
      arm_q        <= arm_d;
      fire_acc_q   <= fire_acc_d;
      inside_q     <= inside_d;
      offset_x_q   <= offset_x_d;
      offset_y_q   <= offset_y_d;
      draw_slot_q  <= draw_slot_d;
      draw_valid_q <= draw_valid_d;
    end
  end

  assign InsideRectangle = inside_q;
  assign offsetX         = offset_x_q;
  assign offsetY         = offset_y_q;
  assign fireAccepted    = fire_acc_q;
  assign activeCount     = count;

endmodule

// File: doc/shot_slot_controller.md
# shot_slot_controller

Owns a fixed pool of projectile slots for the shot bitmap: accepts fire requests from the player logic, allocates a free slot, advances every live shot once per frame, retires shots that leave the top of the screen or register a hit, and arbitrates the single shot bitmap between slots per pixel. It sits between the player/collision logic and the shot bitmap. It drives the bitmap's rectangle-select and offset inputs, one cycle aligned with the pixel stream.

## Interface
- NUM_SLOTS, 4: number of concurrent shots (1..8).
- SHOT_W, 16: shot width in pixels.
- SHOT_H, 16: shot height in pixels.
- SHOT_SPEED, 4: upward move per frame, pixels (1..15).
- COOLDOWN_FRAMES, 8: frames between accepted shots (0..255).

- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- fireReq  in  1  level, player wants to shoot
- fireX  in  11  launch top-left X
- fireY  in  11  launch top-left Y
- shotHit  in  1  collision on the pixel currently drawn by a shot
- InsideRectangle  out  1  pixel lies inside some live shot (registered)
- offsetX  out  11  pixelX minus winning slot X (registered)
- offsetY  out  11  pixelY minus winning slot Y (registered)
- fireAccepted  out  1  one-cycle pulse, shot allocated
- activeCount  out  4  number of live slots

## Operation
- Per slot: active bit, X (11b), Y (11b). Reset: all inactive, X=Y=0.
- Cooldown counter (8b), reset 0.
- Fire arm flag, reset 1.
- Frame update, on the startOfFrame cycle, in this order:
  - Move: each active slot whose Y < SHOT_SPEED is deactivated. Otherwise Y <= Y - SHOT_SPEED. No unsigned wrap is ever stored.
  - Cooldown: if nonzero, it decrements.
  - Fire: accepted when all of the following hold: fireReq=1, cooldown==0 (pre-decrement value), arm=1, and at least one slot is free after the move step.
    - The lowest-index free slot is loaded with (fireX, fireY) and set active.
    - Cooldown is loaded with COOLDOWN_FRAMES.
    - fireAccepted pulses the next cycle.
  - A newly loaded slot is not moved in its launch frame.
  - A full pool drops the request silently. Cooldown is not loaded.
- Pixel arbitration, every cycle:
  - A slot hits the pixel when active, X <= pixelX < X+SHOT_W, and Y <= pixelY < Y+SHOT_H.
  - Sums are computed 12 bits wide, with no wrap.
  - The lowest-index hitting slot wins.
  - The winner's index is registered as drawSlot, with a valid bit.
- Hit retire:
  - shotHit=1 while the registered drawSlot valid=1 deactivates drawSlot at the next edge.
  - shotHit with no valid drawSlot is ignored.
  - If hit and startOfFrame coincide on the same slot, the hit wins: the slot is cleared, and it is free for a fire in that same update.
- activeCount is the combinational popcount of the active bits.

## Timing
- Arbitration latency is 1 cycle: outputs at edge n+1 reflect pixelX/Y at edge n. The shot bitmap then adds its own 1 cycle.
- Reset values: InsideRectangle 0, offsetX 0, offsetY 0, fireAccepted 0, activeCount 0.
- Mid-frame reset clears all slots, cooldown and pulses immediately. arm returns to 1.
- Slot state only changes on startOfFrame or on a hit retire.
- Offsets are stable for a live slot across a frame.

## Configuration
- SHOT_AUTOFIRE_EN defined: arm is held at 1. A held fireReq refires every COOLDOWN_FRAMES+1 frames.
- SHOT_AUTOFIRE_EN undefined:
  - arm clears on an accepted fire.
  - arm sets on any startOfFrame with fireReq=0.
  - The player must release fire between shots.

## Test plan
- Reset, fireReq=1, fireX=100, fireY=400, startOfFrame -> slot0 active at (100,400). fireAccepted pulses once. activeCount=1.
- Scan pixel (107,405) -> one cycle later InsideRectangle=1, offsetX=7, offsetY=5. Pixel (116,405) -> InsideRectangle=0.
- Shot at Y=6, SHOT_SPEED=4 -> next frame Y=2, following frame slot retired, activeCount drops by 1.
- NUM_SLOTS=4, COOLDOWN_FRAMES=0, autofire, fireReq held 5 frames -> 4 shots allocated to slots 0..3. 5th request dropped, no fireAccepted.
- shotHit asserted one cycle after a pixel inside slot2 -> slot2 inactive. Same-cycle startOfFrame with fireReq loads the new shot into slot2 if it is the lowest free slot.
- Without SHOT_AUTOFIRE_EN, fireReq held 20 frames with COOLDOWN_FRAMES=8 -> exactly 1 shot. Release for 1 frame, then press -> second shot accepted.
